five_branch_ctrl: RTL and testbench

// - Branch/halt sequencer driving the 12-bit program counter. Decodes each fetched instruction,

---
 rtl/five_ctrl_pkg.sv | 19 +
 rtl/five_br_decode.sv | 46 ++++
 rtl/five_branch_ctrl.sv | 100 ++++++++++
 tb/tb_five_branch_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/five_ctrl_pkg.sv
// Shared definitions for the branch/halt sequencer: widths, opcodes and FSM states.
package five_ctrl_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;
    localparam int OFF_W   = 8;

    localparam logic [3:0] OP_BZ  = 4'hA;
    localparam logic [3:0] OP_BNZ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/five_br_decode.sv
// Combinational decode of a fetched instruction against the current zero flag.
module five_br_decode
    import five_ctrl_pkg::*;
#(
    parameter int P_ADDR_W  = ADDR_W,
    parameter int P_INSTR_W = INSTR_W,
    parameter int P_OFF_W   = OFF_W
) (
    input  logic [P_INSTR_W-1:0] instr,
    input  logic                 z_q,
    output logic                 take_cond,
    output logic                 take_jmp,
    output logic                 is_hlt,
    output logic [P_ADDR_W-1:0]  offset_sext,
    output logic [P_ADDR_W-1:0]  target
);

    logic [3:0] opcode;

    assign opcode = instr[P_INSTR_W-1 -: 4];

    always_comb begin
        take_cond = 1'b0;
        take_jmp  = 1'b0;
        is_hlt    = 1'b0;
        case (opcode)
            OP_BZ:   take_cond = z_q;
            OP_BNZ:  take_cond = ~z_q;
            OP_JMP:  take_jmp  = 1'b1;
            OP_HLT:  is_hlt    = 1'b1;
            default: ;
        endcase
    end

    // Bits above the offset field replicate its sign bit.
    for (genvar gi = 0; gi < P_ADDR_W; gi++) begin : g_sext
        if (gi < P_OFF_W) begin : g_low
            assign offset_sext[gi] = instr[gi];
        end else begin : g_high
            assign offset_sext[gi] = instr[P_OFF_W-1];
        end
    end

    assign target = instr[P_ADDR_W-1:0];

endmodule

// File: rtl/five_branch_ctrl.sv
// Branch/halt sequencer: RUN/FLUSH/HALT FSM, zero-flag register and registered PC controls.
module five_branch_ctrl
    import five_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    input  logic               alu_zero,
    input  logic               alu_flag_we,
    input  logic               resume,
    output logic               cond_br,
    output logic               jmp,
    output logic               stop,
    output logic [ADDR_W-1:0]  br_offset,
    output logic [ADDR_W-1:0]  jmp_target,
    output logic               busy_flush
);

    state_t              state_reg, state_next;
    logic                z_reg;
    logic                cond_br_reg, cond_br_next;
    logic                jmp_reg, jmp_next;
    logic                stop_reg, busy_flush_reg;
    logic [ADDR_W-1:0]   br_offset_reg, br_offset_next;
    logic [ADDR_W-1:0]   jmp_target_reg, jmp_target_next;

    logic                take_cond, take_jmp, is_hlt;
    logic [ADDR_W-1:0]   offset_sext, target;

    five_br_decode u_decode (
        .instr       (instr),
        .z_q         (z_reg),
        .take_cond   (take_cond),
        .take_jmp    (take_jmp),
        .is_hlt      (is_hlt),
        .offset_sext (offset_sext),
        .target      (target)
    );

    always_comb begin
        state_next      = state_reg;
        cond_br_next    = 1'b0;
        jmp_next        = 1'b0;
        br_offset_next  = br_offset_reg;
        jmp_target_next = jmp_target_reg;
        case (state_reg)
            RUN: begin
                if (instr_valid) begin
                    if (take_cond) begin
                        cond_br_next   = 1'b1;
                        br_offset_next = offset_sext;
                        state_next     = FLUSH;
                    end else if (take_jmp) begin
                        jmp_next        = 1'b1;
                        jmp_target_next = target;
                        state_next      = FLUSH;
                    end else if (is_hlt) begin
                        state_next = HALT;
                    end
                end
            end
            // The instruction fetched behind a taken control transfer is dropped undecoded.
            FLUSH: if (instr_valid) state_next = RUN;
            HALT:  if (resume) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            z_reg          <= 1'b0;
            cond_br_reg    <= 1'b0;
            jmp_reg        <= 1'b0;
            stop_reg       <= 1'b0;
            busy_flush_reg <= 1'b0;
            br_offset_reg  <= '0;
            jmp_target_reg <= '0;
        end else begin
            state_reg      <= state_next;
            // Decode above reads the old flag; the written value is seen next cycle.
            if (alu_flag_we) z_reg <= alu_zero;
            cond_br_reg    <= cond_br_next;
            jmp_reg        <= jmp_next;
            stop_reg       <= (state_next == HALT);
            busy_flush_reg <= (state_next == FLUSH);
            br_offset_reg  <= br_offset_next;
            jmp_target_reg <= jmp_target_next;
        end
    end

    assign cond_br    = cond_br_reg;
    assign jmp        = jmp_reg;
    assign stop       = stop_reg;
    assign busy_flush = busy_flush_reg;
    assign br_offset  = br_offset_reg;
    assign jmp_target = jmp_target_reg;

endmodule

// File: tb/tb_five_branch_ctrl.sv
// Directed-vector bench for five_branch_ctrl with a queue-based scoreboard and negedge monitor.
module tb_five_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        alu_zero;
    logic        alu_flag_we;
    logic        resume;
    logic        cond_br;
    logic        jmp;
    logic        stop;
    logic [11:0] br_offset;
    logic [11:0] jmp_target;
    logic        busy_flush;

    typedef struct packed {
        logic        cond_br;
        logic        jmp;
        logic        stop;
        logic        busy;
        logic [11:0] off;
        logic [11:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_step   = 0;

    five_branch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .alu_zero    (alu_zero),
        .alu_flag_we (alu_flag_we),
        .resume      (resume),
        .cond_br     (cond_br),
        .jmp         (jmp),
        .stop        (stop),
        .br_offset   (br_offset),
        .jmp_target  (jmp_target),
        .busy_flush  (busy_flush)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                        input logic we, input logic zero, input logic res,
                        input logic e_cond, input logic e_jmp, input logic e_stop,
                        input logic e_busy, input logic [11:0] e_off, input logic [11:0] e_tgt);
        exp_t e;
        rst = r; instr_valid = iv; instr = ins;
        alu_flag_we = we; alu_zero = zero; resume = res;
        @(posedge clk);
        e.cond_br = e_cond; e.jmp = e_jmp; e.stop = e_stop;
        e.busy = e_busy; e.off = e_off; e.tgt = e_tgt;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_step++;
                chk("cond_br",    n_step, {11'd0, cond_br},    {11'd0, e.cond_br});
                chk("jmp",        n_step, {11'd0, jmp},        {11'd0, e.jmp});
                chk("stop",       n_step, {11'd0, stop},       {11'd0, e.stop});
                chk("busy_flush", n_step, {11'd0, busy_flush}, {11'd0, e.busy});
                chk("br_offset",  n_step, br_offset,           e.off);
                chk("jmp_target", n_step, jmp_target,          e.tgt);
                $display("step %0d: cond_br=%b jmp=%b stop=%b busy=%b off=%h tgt=%h",
                         n_step, cond_br, jmp, stop, busy_flush, br_offset, jmp_target);
            end
        end
    end

    initial begin
        //    rst iv instr     we z  res  cond jmp stop busy off     tgt
        step(1, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000);
        step(1, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000);
        step(0, 1, 16'hA001, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000); // BZ, z=0 after reset
        step(0, 1, 16'hC002, 0, 0, 0,   1, 0, 0, 1, 12'h002, 12'h000); // BNZ taken
        step(0, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 1, 12'h002, 12'h000); // still flushing
        step(0, 1, 16'hB010, 0, 0, 0,   0, 0, 0, 0, 12'h002, 12'h000); // discarded JMP
        step(0, 0, 16'h0000, 1, 1, 0,   0, 0, 0, 0, 12'h002, 12'h000); // z<=1
        step(0, 1, 16'hA005, 0, 0, 0,   1, 0, 0, 1, 12'h005, 12'h000);
        step(0, 1, 16'hB010, 0, 0, 0,   0, 0, 0, 0, 12'h005, 12'h000); // discarded
        step(0, 1, 16'hC0FF, 0, 0, 0,   0, 0, 0, 0, 12'h005, 12'h000); // BNZ, z=1 untaken
        step(0, 0, 16'h0000, 1, 0, 0,   0, 0, 0, 0, 12'h005, 12'h000); // z<=0
        step(0, 1, 16'hC0FF, 0, 0, 0,   1, 0, 0, 1, 12'hFFF, 12'h000); // -1 offset
        step(0, 1, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'hFFF, 12'h000);
        step(0, 1, 16'hB003, 0, 0, 0,   0, 1, 0, 1, 12'hFFF, 12'h003); // JMP
        step(0, 1, 16'h1234, 0, 0, 0,   0, 0, 0, 0, 12'hFFF, 12'h003);
        step(0, 1, 16'hF000, 0, 0, 0,   0, 0, 1, 0, 12'hFFF, 12'h003); // HLT
        step(0, 1, 16'hB001, 0, 0, 0,   0, 0, 1, 0, 12'hFFF, 12'h003); // ignored in HALT
        step(0, 0, 16'h0000, 1, 1, 0,   0, 0, 1, 0, 12'hFFF, 12'h003); // z<=1 during HALT
        step(0, 0, 16'h0000, 0, 0, 1,   0, 0, 0, 0, 12'hFFF, 12'h003); // resume
        step(0, 1, 16'hA7F0, 0, 0, 0,   1, 0, 0, 1, 12'hFF0, 12'h003); // BZ taken, -16
        step(0, 1, 16'h0000, 1, 0, 0,   0, 0, 0, 0, 12'hFF0, 12'h003); // z<=0 during FLUSH
        step(0, 1, 16'hC001, 0, 0, 0,   1, 0, 0, 1, 12'h001, 12'h003);
        step(0, 1, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h001, 12'h003);
        step(0, 1, 16'hA003, 1, 1, 0,   0, 0, 0, 0, 12'h001, 12'h003); // uses old z=0
        step(0, 1, 16'hA004, 0, 0, 0,   1, 0, 0, 1, 12'h004, 12'h003); // new z=1 visible
        step(0, 1, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h004, 12'h003);
        step(0, 1, 16'hF000, 0, 0, 0,   0, 0, 1, 0, 12'h004, 12'h003);
        step(0, 0, 16'h0000, 0, 0, 0,   0, 0, 1, 0, 12'h004, 12'h003);
        step(1, 0, 16'h0000, 0, 0, 1,   0, 0, 0, 0, 12'h000, 12'h000); // rst beats resume
        step(0, 1, 16'hA001, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000); // z cleared
        step(0, 1, 16'hF000, 0, 0, 0,   0, 0, 1, 0, 12'h000, 12'h000);
        step(1, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000); // rst mid-HALT
        step(1, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000);
        step(0, 1, 16'hC001, 0, 0, 0,   1, 0, 0, 1, 12'h001, 12'h000);
        step(1, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 0, 12'h000, 12'h000); // rst mid-FLUSH
        step(0, 1, 16'hB005, 0, 0, 0,   0, 1, 0, 1, 12'h000, 12'h005); // decoded, not flushed
        step(0, 0, 16'h0000, 0, 0, 0,   0, 0, 0, 1, 12'h000, 12'h005);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
